// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Packages : io_stage_params, wb_stage_params
//  Brief    : Shared types for the IO->WB handoff and the WB stage outputs,
//             CP0 selector / field constants and exception codes.
//  Revision : 1.0  initial release
// ============================================================================

package io_stage_params;

    // Instruction leaving the IO (memory) stage towards WB.
    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [4:0]  rf_write_address;
        logic        rf_write_enabled;
        logic [3:0]  rf_write_strobe;
        logic [4:0]  cp0_address_register;
        logic [2:0]  cp0_select;
        logic        move_from_cp0;
        logic        move_to_cp0;
        logic        exception_valid;
        logic        in_delay_slot;
        logic        eret_flush;
        logic [4:0]  exception_code;
    } IOToWBData;

endpackage

package wb_stage_params;

    typedef struct packed {
        logic        exception_valid;
        logic        eret_flush;
        logic [31:0] target_pc;
        logic        interrupt_pending;
    } WBExceptionBus;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [3:0]  write_strobe;
        logic [31:0] write_data;
    } WBToIDBackPassData;

    // CP0 selectors, encoded as {register, select}.
    localparam logic [7:0] c_cp0_count   = {5'd9,  3'd0};
    localparam logic [7:0] c_cp0_compare = {5'd11, 3'd0};
    localparam logic [7:0] c_cp0_status  = {5'd12, 3'd0};
    localparam logic [7:0] c_cp0_cause   = {5'd13, 3'd0};
    localparam logic [7:0] c_cp0_epc     = {5'd14, 3'd0};

    // Exception codes.
    localparam logic [4:0] c_exc_int  = 5'd0;
    localparam logic [4:0] c_exc_adel = 5'd4;
    localparam logic [4:0] c_exc_ades = 5'd5;
    localparam logic [4:0] c_exc_sys  = 5'd8;
    localparam logic [4:0] c_exc_bp   = 5'd9;
    localparam logic [4:0] c_exc_ri   = 5'd10;
    localparam logic [4:0] c_exc_ov   = 5'd12;

    // Status field positions.
    localparam int c_status_ie_bit  = 0;
    localparam int c_status_exl_bit = 1;
    localparam int c_status_im_lo   = 8;
    localparam int c_status_im_hi   = 15;

    // Cause field positions.
    localparam int c_cause_exc_lo = 2;
    localparam int c_cause_exc_hi = 6;
    localparam int c_cause_ip_lo  = 8;
    localparam int c_cause_ip_hi  = 15;
    localparam int c_cause_ti_bit = 30;
    localparam int c_cause_bd_bit = 31;

endpackage

`default_nettype wire

// File: rtl/wb_stage_cp0.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_register_file
//  Brief    : CP0 Status/Cause/EPC (and optional Count/Compare timer),
//             interrupt sampling, pending-interrupt detection and read mux.
//             Build option: define CP0_TIMER_EN to include Count/Compare.
//  Revision : 1.0  initial release
// ============================================================================
module cp0_register_file
    import wb_stage_params::*;
#(
    parameter logic [31:0] CP0_STATUS_RESET = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  hardware_interrupt,
    input  logic        exception_commit,
    input  logic [4:0]  exception_code,
    input  logic        in_delay_slot,
    input  logic [31:0] exception_pc,
    input  logic        eret_commit,
    input  logic        mtc0_write,
    input  logic [4:0]  cp0_address_register,
    input  logic [2:0]  cp0_select,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] epc,
    output logic        interrupt_pending
);

    logic [7:0]  w_sel;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] r_status;
    logic        r_cause_bd;
    logic [4:0]  r_cause_exc;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [31:0] r_epc;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_cause;
    logic [7:0]  w_ip;

    assign w_sel       = {cp0_address_register, cp0_select};
    assign w_wr_status = mtc0_write & (w_sel == c_cp0_status);
    assign w_wr_cause  = mtc0_write & (w_sel == c_cp0_cause);
    assign w_wr_epc    = mtc0_write & (w_sel == c_cp0_epc);

`ifdef CP0_TIMER_EN
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_timer_match;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_ti;

    assign w_wr_count    = mtc0_write & (w_sel == c_cp0_count);
    assign w_wr_compare  = mtc0_write & (w_sel == c_cp0_compare);
    // A match only counts on a real increment; a software Count write overrides the tick.
    assign w_timer_match = r_tick & ~w_wr_count & ((r_count + 32'd1) == r_compare);

    // Half-rate Count, Compare register and sticky timer interrupt (Compare write clears it).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_tick    <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= write_data;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end
            if (w_wr_compare) begin
                r_compare <= write_data;
            end
            if (w_wr_compare) begin
                r_ti <= 1'b0;
            end else if (w_timer_match) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    // Status: exception entry sets EXL, ERET clears it, MTC0 updates IM/EXL/IE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_status <= CP0_STATUS_RESET;
        end else if (exception_commit) begin
            r_status[c_status_exl_bit] <= 1'b1;
        end else begin
            if (eret_commit) begin
                r_status[c_status_exl_bit] <= 1'b0;
            end
            if (w_wr_status) begin
                r_status[c_status_im_hi:c_status_im_lo] <= write_data[c_status_im_hi:c_status_im_lo];
                r_status[c_status_exl_bit]              <= write_data[c_status_exl_bit];
                r_status[c_status_ie_bit]               <= write_data[c_status_ie_bit];
            end
        end
    end

    // Cause/EPC: sample interrupt lines each cycle; record exception context; MTC0 updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cause_bd    <= 1'b0;
            r_cause_exc   <= 5'd0;
            r_cause_ip_hw <= 6'd0;
            r_cause_ip_sw <= 2'd0;
            r_epc         <= 32'd0;
        end else begin
            r_cause_ip_hw <= {hardware_interrupt[5] | w_ti, hardware_interrupt[4:0]};
            if (exception_commit) begin
                // A nested exception (EXL already set) keeps the original EPC/BD.
                if (!r_status[c_status_exl_bit]) begin
                    r_epc      <= in_delay_slot ? (exception_pc - 32'd4) : exception_pc;
                    r_cause_bd <= in_delay_slot;
                end
                r_cause_exc <= exception_code;
            end else begin
                if (w_wr_cause) begin
                    r_cause_ip_sw <= write_data[c_cause_ip_lo+1:c_cause_ip_lo];
                end
                if (w_wr_epc) begin
                    r_epc <= write_data;
                end
            end
        end
    end

    assign w_ip    = {r_cause_ip_hw, r_cause_ip_sw};
    assign w_cause = {r_cause_bd, w_ti, 14'd0, w_ip, 1'b0, r_cause_exc, 2'b00};

    assign interrupt_pending = (|(w_ip & r_status[c_status_im_hi:c_status_im_lo]))
                             & r_status[c_status_ie_bit]
                             & ~r_status[c_status_exl_bit];

    assign epc = r_epc;

    // CP0 read mux; unimplemented selectors read as zero.
    always_comb begin
        read_data = 32'd0;
        case (w_sel)
            c_cp0_status:  read_data = r_status;
            c_cp0_cause:   read_data = w_cause;
            c_cp0_epc:     read_data = r_epc;
            c_cp0_count:   read_data = w_count;
            c_cp0_compare: read_data = w_compare;
            default:       read_data = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : Final MIPS pipeline stage: register-file commit with byte
//             strobes, precise exception / ERET flush, CP0 ownership,
//             debug trace and ID back-pass.
//             Build option: CP0_TIMER_EN (Count/Compare timer in CP0).
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage
    import io_stage_params::*;
    import wb_stage_params::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY  = 32'hBFC0_0380,
    parameter logic [31:0] CP0_STATUS_RESET = 32'h0040_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  IOToWBData         io_to_wb_bus,
    input  logic [5:0]        hardware_interrupt,
    output logic              wb_allow_in,
    output WBExceptionBus     wb_exception_bus,
    output WBToIDBackPassData wb_to_id_back_pass_bus,
    output logic [3:0]        register_file_write_enable,
    output logic [4:0]        register_file_write_address,
    output logic [31:0]       register_file_write_data,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    IOToWBData   r_bus;
    logic        w_wb_valid;
    logic        w_exception;
    logic        w_eret;
    logic        w_flush;
    logic        w_mtc0;
    logic        w_commit;
    logic [31:0] w_cp0_read_data;
    logic [31:0] w_epc;
    logic        w_interrupt_pending;
    logic [31:0] w_write_data;
    logic [3:0]  w_write_enable;

    assign wb_allow_in = 1'b1;

    // The latched bus's own valid bit is the stage-valid flag.
    assign w_wb_valid  = r_bus.valid;
    assign w_exception = w_wb_valid & r_bus.exception_valid;
    assign w_eret      = w_wb_valid & r_bus.eret_flush & ~r_bus.exception_valid;
    assign w_flush     = w_exception | w_eret;
    assign w_mtc0      = w_wb_valid & r_bus.move_to_cp0 & ~r_bus.exception_valid;
    assign w_commit    = w_wb_valid & r_bus.rf_write_enabled & ~r_bus.exception_valid;

    // Stage register: accept from IO; a flush leaving WB kills whatever arrives with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus <= '0;
        end else if (w_flush) begin
            r_bus.valid <= 1'b0;
        end else if (wb_allow_in) begin
            if (io_to_wb_bus.valid) begin
                r_bus <= io_to_wb_bus;
            end else begin
                r_bus.valid <= 1'b0;
            end
        end
    end

    cp0_register_file #(
        .CP0_STATUS_RESET (CP0_STATUS_RESET)
    ) u_cp0 (
        .clock                (clock),
        .reset                (reset),
        .hardware_interrupt   (hardware_interrupt),
        .exception_commit     (w_exception),
        .exception_code       (r_bus.exception_code),
        .in_delay_slot        (r_bus.in_delay_slot),
        .exception_pc         (r_bus.program_count),
        .eret_commit          (w_eret),
        .mtc0_write           (w_mtc0),
        .cp0_address_register (r_bus.cp0_address_register),
        .cp0_select           (r_bus.cp0_select),
        .write_data           (r_bus.final_result),
        .read_data            (w_cp0_read_data),
        .epc                  (w_epc),
        .interrupt_pending    (w_interrupt_pending)
    );

    assign w_write_data   = r_bus.move_from_cp0 ? w_cp0_read_data : r_bus.final_result;
    assign w_write_enable = {4{w_commit}} & r_bus.rf_write_strobe;

    assign register_file_write_enable  = w_write_enable;
    assign register_file_write_address = r_bus.rf_write_address;
    assign register_file_write_data    = w_write_data;

    assign debug_wb_pc       = r_bus.program_count;
    assign debug_wb_rf_wen   = w_write_enable;
    assign debug_wb_rf_wnum  = r_bus.rf_write_address;
    assign debug_wb_rf_wdata = w_write_data;

    // Flush request towards the upstream stages; exception takes priority over ERET.
    always_comb begin
        wb_exception_bus                   = '0;
        wb_exception_bus.exception_valid   = w_exception;
        wb_exception_bus.eret_flush        = w_eret;
        wb_exception_bus.interrupt_pending = w_interrupt_pending;
        if (w_exception) begin
            wb_exception_bus.target_pc = EXCEPTION_ENTRY;
        end else if (w_eret) begin
            wb_exception_bus.target_pc = w_epc;
        end
    end

    // Pending register write exposed to ID for forwarding and interlock.
    always_comb begin
        wb_to_id_back_pass_bus                = '0;
        wb_to_id_back_pass_bus.valid          = w_wb_valid & r_bus.rf_write_enabled;
        wb_to_id_back_pass_bus.write_register = r_bus.rf_write_address;
        wb_to_id_back_pass_bus.write_strobe   = r_bus.rf_write_strobe;
        wb_to_id_back_pass_bus.write_data     = w_write_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Brief    : Directed self-checking bench for wb_stage (commit, LWL strobe,
//             exception, MTC0/ERET, interrupts, optional CP0_TIMER_EN timer,
//             asynchronous reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;
    import io_stage_params::*;
    import wb_stage_params::*;

    logic              clock;
    logic              reset;
    IOToWBData         io_to_wb_bus;
    logic [5:0]        hardware_interrupt;
    logic              wb_allow_in;
    WBExceptionBus     wb_exception_bus;
    WBToIDBackPassData wb_to_id_back_pass_bus;
    logic [3:0]        register_file_write_enable;
    logic [4:0]        register_file_write_address;
    logic [31:0]       register_file_write_data;
    logic [31:0]       debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;

    int errors = 0;
    int checks = 0;

    wb_stage dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_to_wb_bus                (io_to_wb_bus),
        .hardware_interrupt          (hardware_interrupt),
        .wb_allow_in                 (wb_allow_in),
        .wb_exception_bus            (wb_exception_bus),
        .wb_to_id_back_pass_bus      (wb_to_id_back_pass_bus),
        .register_file_write_enable  (register_file_write_enable),
        .register_file_write_address (register_file_write_address),
        .register_file_write_data    (register_file_write_data),
        .debug_wb_pc                 (debug_wb_pc),
        .debug_wb_rf_wen             (debug_wb_rf_wen),
        .debug_wb_rf_wnum            (debug_wb_rf_wnum),
        .debug_wb_rf_wdata           (debug_wb_rf_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_cp0(input logic [4:0] addr, input logic [31:0] data);
        io_to_wb_bus                      = '0;
        io_to_wb_bus.valid                = 1'b1;
        io_to_wb_bus.move_to_cp0          = 1'b1;
        io_to_wb_bus.cp0_address_register = addr;
        io_to_wb_bus.final_result         = data;
        step();
        io_to_wb_bus = '0;
    endtask

    task automatic read_cp0(input string tag, input logic [4:0] addr, input logic [2:0] sel,
                            input logic [31:0] exp);
        io_to_wb_bus                      = '0;
        io_to_wb_bus.valid                = 1'b1;
        io_to_wb_bus.move_from_cp0        = 1'b1;
        io_to_wb_bus.rf_write_enabled     = 1'b1;
        io_to_wb_bus.rf_write_strobe      = 4'b1111;
        io_to_wb_bus.rf_write_address     = 5'd2;
        io_to_wb_bus.cp0_address_register = addr;
        io_to_wb_bus.cp0_select           = sel;
        io_to_wb_bus.final_result         = 32'hDEAD_BEEF;
        step();
        chk(tag, register_file_write_data, exp);
        io_to_wb_bus = '0;
    endtask

    initial begin
        logic hit;
        reset              = 1'b1;
        io_to_wb_bus       = '0;
        hardware_interrupt = 6'd0;
        step();
        chk("reset_allow_in", {31'd0, wb_allow_in}, 32'd1);
        chk("reset_we", {28'd0, register_file_write_enable}, 32'd0);
        chk("reset_exc", {30'd0, wb_exception_bus.exception_valid, wb_exception_bus.eret_flush}, 32'd0);
        chk("reset_target", wb_exception_bus.target_pc, 32'd0);
        chk("reset_bp_valid", {31'd0, wb_to_id_back_pass_bus.valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // ADDU r5 <- 0x12345678
        io_to_wb_bus                  = '0;
        io_to_wb_bus.valid            = 1'b1;
        io_to_wb_bus.program_count    = 32'hBFC0_0000;
        io_to_wb_bus.final_result     = 32'h1234_5678;
        io_to_wb_bus.rf_write_enabled = 1'b1;
        io_to_wb_bus.rf_write_strobe  = 4'b1111;
        io_to_wb_bus.rf_write_address = 5'd5;
        step();
        io_to_wb_bus = '0;
        chk("addu_we", {28'd0, register_file_write_enable}, 32'hF);
        chk("addu_addr", {27'd0, register_file_write_address}, 32'd5);
        chk("addu_data", register_file_write_data, 32'h1234_5678);
        chk("addu_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
        chk("addu_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
        chk("addu_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
        chk("addu_dbg_wdata", debug_wb_rf_wdata, 32'h1234_5678);
        chk("addu_bp", {wb_to_id_back_pass_bus.valid, 26'd0, wb_to_id_back_pass_bus.write_register},
            32'h8000_0005);
        step();
        chk("idle_we", {28'd0, register_file_write_enable}, 32'd0);

        // LWL with partial strobe
        io_to_wb_bus                  = '0;
        io_to_wb_bus.valid            = 1'b1;
        io_to_wb_bus.program_count    = 32'hBFC0_0004;
        io_to_wb_bus.final_result     = 32'hAABB_0000;
        io_to_wb_bus.rf_write_enabled = 1'b1;
        io_to_wb_bus.rf_write_strobe  = 4'b1100;
        io_to_wb_bus.rf_write_address = 5'd7;
        step();
        io_to_wb_bus = '0;
        chk("lwl_we", {28'd0, register_file_write_enable}, 32'hC);
        chk("lwl_bp_strobe", {28'd0, wb_to_id_back_pass_bus.write_strobe}, 32'hC);
        chk("lwl_bp_data", wb_to_id_back_pass_bus.write_data, 32'hAABB_0000);

        read_cp0("status_reset", 5'd12, 3'd0, 32'h0040_0000);
        read_cp0("unimpl_read", 5'd15, 3'd0, 32'd0);

        // Syscall in a delay slot, also carries an rf write that must be suppressed
        io_to_wb_bus                  = '0;
        io_to_wb_bus.valid            = 1'b1;
        io_to_wb_bus.program_count    = 32'hBFC0_0100;
        io_to_wb_bus.in_delay_slot    = 1'b1;
        io_to_wb_bus.exception_valid  = 1'b1;
        io_to_wb_bus.exception_code   = 5'd8;
        io_to_wb_bus.rf_write_enabled = 1'b1;
        io_to_wb_bus.rf_write_strobe  = 4'b1111;
        io_to_wb_bus.rf_write_address = 5'd3;
        step();
        chk("sys_exc", {31'd0, wb_exception_bus.exception_valid}, 32'd1);
        chk("sys_target", wb_exception_bus.target_pc, 32'hBFC0_0380);
        chk("sys_no_we", {28'd0, register_file_write_enable}, 32'd0);
        // A valid instruction arriving on the flush edge must be dropped
        io_to_wb_bus                  = '0;
        io_to_wb_bus.valid            = 1'b1;
        io_to_wb_bus.program_count    = 32'hBFC0_0104;
        io_to_wb_bus.final_result     = 32'h0000_0099;
        io_to_wb_bus.rf_write_enabled = 1'b1;
        io_to_wb_bus.rf_write_strobe  = 4'b1111;
        io_to_wb_bus.rf_write_address = 5'd9;
        step();
        io_to_wb_bus = '0;
        chk("drop_we", {28'd0, register_file_write_enable}, 32'd0);
        chk("drop_exc", {31'd0, wb_exception_bus.exception_valid}, 32'd0);
        read_cp0("sys_epc", 5'd14, 3'd0, 32'hBFC0_00FC);
        read_cp0("sys_cause", 5'd13, 3'd0, 32'h8000_0020);
        read_cp0("sys_status", 5'd12, 3'd0, 32'h0040_0002);

        // MTC0 EPC then ERET
        write_cp0(5'd14, 32'hBFC0_2000);
        io_to_wb_bus            = '0;
        io_to_wb_bus.valid      = 1'b1;
        io_to_wb_bus.eret_flush = 1'b1;
        step();
        io_to_wb_bus = '0;
        chk("eret_flush", {30'd0, wb_exception_bus.exception_valid, wb_exception_bus.eret_flush}, 32'd1);
        chk("eret_target", wb_exception_bus.target_pc, 32'hBFC0_2000);
        step();
        read_cp0("eret_status", 5'd12, 3'd0, 32'h0040_0000);

        // Software interrupt IP0 with IM0/IE
        write_cp0(5'd13, 32'h0000_0100);
        write_cp0(5'd12, 32'h0000_0101);
        step();
        chk("sw_irq", {31'd0, wb_exception_bus.interrupt_pending}, 32'd1);
        read_cp0("sw_cause", 5'd13, 3'd0, 32'h8000_0120);
        write_cp0(5'd13, 32'h0000_0000);
        step();
        chk("sw_irq_clr", {31'd0, wb_exception_bus.interrupt_pending}, 32'd0);

        // Hardware interrupt line 2 -> IP4 (bit 12)
        write_cp0(5'd12, 32'h0000_1001);
        hardware_interrupt = 6'b000100;
        step();
        chk("hw_irq", {31'd0, wb_exception_bus.interrupt_pending}, 32'd1);
        read_cp0("hw_cause", 5'd13, 3'd0, 32'h8000_1020);
        hardware_interrupt = 6'd0;
        step();
        chk("hw_irq_clr", {31'd0, wb_exception_bus.interrupt_pending}, 32'd0);

`ifdef CP0_TIMER_EN
        write_cp0(5'd11, 32'd10);
        write_cp0(5'd9, 32'd0);
        write_cp0(5'd12, 32'h0000_8001);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            hit = wb_exception_bus.interrupt_pending;
        end
        chk("timer_irq", {31'd0, hit}, 32'd1);
        read_cp0("timer_cause", 5'd13, 3'd0, 32'hC000_8020);
        write_cp0(5'd11, 32'd100);
        step();
        step();
        chk("timer_clr", {31'd0, wb_exception_bus.interrupt_pending}, 32'd0);
`else
        hit = 1'b0;
        write_cp0(5'd9, 32'h0000_0055);
        read_cp0("count_absent", 5'd9, 3'd0, 32'd0);
        chk("no_timer_irq", {31'd0, hit | wb_exception_bus.interrupt_pending}, 32'd0);
`endif

        // Asynchronous reset in the middle of a commit
        io_to_wb_bus                  = '0;
        io_to_wb_bus.valid            = 1'b1;
        io_to_wb_bus.final_result     = 32'h0000_0AAA;
        io_to_wb_bus.rf_write_enabled = 1'b1;
        io_to_wb_bus.rf_write_strobe  = 4'b1111;
        io_to_wb_bus.rf_write_address = 5'd1;
        step();
        io_to_wb_bus = '0;
        chk("pre_reset_we", {28'd0, register_file_write_enable}, 32'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_we", {28'd0, register_file_write_enable}, 32'd0);
        chk("async_reset_dbg", {28'd0, debug_wb_rf_wen}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        read_cp0("post_reset_status", 5'd12, 3'd0, 32'h0040_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
